// File: rtl/nand_cpu_pkg.sv
// Shared CPU types: register-file geometry, register address and data word types.
package nand_cpu_pkg;

    localparam int unsigned REG_COUNT  = 16;
    localparam int unsigned REG_ADDR_W = $clog2(REG_COUNT);
    localparam int unsigned DATA_W     = 16;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0]     word_t;

    // True when a writeback bundle updates a general register.
    function automatic logic wb_writes_reg(input logic valid, input logic use_rw);
        return valid & use_rw;
    endfunction

    // True when a writeback bundle updates the predicate flag.
    function automatic logic wb_writes_ps(input logic valid, input logic write_ps);
        return valid & write_ps;
    endfunction

endpackage : nand_cpu_pkg

// File: rtl/writeback_ifc.sv
// Writeback-stage bundle: at most one register and/or predicate update per cycle.
interface writeback_ifc;
    import nand_cpu_pkg::*;

    logic      valid;
    logic      use_rw;
    reg_addr_t rw_addr;
    word_t     data;
    logic      write_ps;
    logic      ps;

    modport in (
        input valid,
        input use_rw,
        input rw_addr,
        input data,
        input write_ps,
        input ps
    );

    modport out (
        output valid,
        output use_rw,
        output rw_addr,
        output data,
        output write_ps,
        output ps
    );

endinterface : writeback_ifc

// File: rtl/regfile_bank.sv
// Storage array for the general registers: one write port, two combinational read ports.
module regfile_bank #(
    parameter int unsigned NUM_REGS = 16,
    parameter int unsigned WORD_W   = 16,
    localparam int unsigned ADDR_W  = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WORD_W-1:0] rdata_a_c,
    output logic [WORD_W-1:0] rdata_b_c
);

    logic [WORD_W-1:0] mem [NUM_REGS];

    // Register array: async clear, single decoded write per edge (r0 is an ordinary register).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Independent read muxes; reads return stored state only.
    always_comb begin
        rdata_a_c = mem[raddr_a];
        rdata_b_c = mem[raddr_b];
    end

endmodule : regfile_bank

// File: rtl/register_file.sv
// Architectural register file: 16 general registers, predicate flag ps and retire counter.
// Build option: define REGFILE_BYPASS_EN to forward the same-cycle writeback onto ra/rt/ps.
module register_file
    import nand_cpu_pkg::*;
#(
    parameter int unsigned RETIRE_W = 16
) (
    input  logic                clk,
    input  logic                rst,
    writeback_ifc.in            wb,
    input  reg_addr_t           ra_addr,
    input  reg_addr_t           rt_addr,
    output word_t               ra,
    output word_t               rt,
    output logic                ps,
    output logic [RETIRE_W-1:0] retire_count
);

    logic  reg_we_c;
    logic  ps_we_c;
    logic  ps_q;
    word_t ra_store_c;
    word_t rt_store_c;

    assign reg_we_c = wb_writes_reg(wb.valid, wb.use_rw);
    assign ps_we_c  = wb_writes_ps(wb.valid, wb.write_ps);

    regfile_bank #(
        .NUM_REGS (REG_COUNT),
        .WORD_W   (DATA_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .we        (reg_we_c),
        .waddr     (wb.rw_addr),
        .wdata     (wb.data),
        .raddr_a   (ra_addr),
        .raddr_b   (rt_addr),
        .rdata_a_c (ra_store_c),
        .rdata_b_c (rt_store_c)
    );

    // Predicate flag: updated by any valid writeback that requests it, independent of use_rw.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ps_q <= 1'b0;
        end else if (ps_we_c) begin
            ps_q <= wb.ps;
        end
    end

    // Retire counter: one per valid writeback, silently wraps.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_count <= '0;
        end else if (wb.valid) begin
            retire_count <= retire_count + RETIRE_W'(1);
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forward the in-flight writeback so a same-cycle reader sees the new value.
    always_comb begin
        ra = ra_store_c;
        rt = rt_store_c;
        ps = ps_q;
        if (reg_we_c && (wb.rw_addr == ra_addr)) begin
            ra = wb.data;
        end
        if (reg_we_c && (wb.rw_addr == rt_addr)) begin
            rt = wb.data;
        end
        if (ps_we_c) begin
            ps = wb.ps;
        end
    end
`else
    // Outputs reflect stored state only; a write becomes visible after its edge.
    always_comb begin
        ra = ra_store_c;
        rt = rt_store_c;
        ps = ps_q;
    end
`endif

endmodule : register_file

// File: doc/register_file.md
Name: register_file

Overview:
- Architectural state block: 16 x 16-bit general registers plus the 1-bit predicate/status flag (ps).
- Consumes the writeback_ifc bundle from the writeback stage.
- Supplies the ra/rt read operands to the operand-select logic in front of the ALU.
- Also keeps a retired-instruction counter used by the bench and debug.

Parameters:
- REG_COUNT, 16, number of general registers; must be a power of two.
- DATA_W, 16, register and operand width in bits.
- RETIRE_W, 16, width of the retired-instruction counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- wb  input  writeback_ifc.in  writeback bundle: valid, use_rw, rw_addr[3:0], data[15:0], write_ps, ps.
- ra_addr  input  4  read address, port A.
- rt_addr  input  4  read address, port T.
- ra  output  DATA_W  register[ra_addr].
- rt  output  DATA_W  register[rt_addr].
- ps  output  1  current predicate flag.
- retire_count  output  RETIRE_W  number of valid writebacks since reset.

Behaviour:
- Reset:
  - Asserting rst immediately (asynchronously) clears all registers, ps and retire_count to 0.
  - ra and rt then read 0.
  - Reset asserted mid-write wins: the write in that cycle is lost.
  - After rst deasserts, the first rising edge is a normal update.
- Register write:
  - On the rising edge, if wb.valid && wb.use_rw, then register[wb.rw_addr] <= wb.data.
  - No register is hardwired; r0 is writable.
  - Otherwise all registers hold.
- PS write:
  - On the rising edge, if wb.valid && wb.write_ps, then ps <= wb.ps.
  - Independent of use_rw; both may update in the same cycle.
- Invalid writeback:
  - wb.valid = 0 blocks all writes and counting, whatever use_rw and write_ps are.
- Reads:
  - Combinational, zero latency, two fully independent ports.
  - ra_addr == rt_addr is legal; both outputs show the same value.
- Read during write to the same address (bypass disabled):
  - Output shows the old value in the write cycle and the new value from the next cycle.
- Retire counter:
  - Increments by 1 on each rising edge with wb.valid = 1, regardless of use_rw and write_ps.
  - Wraps from 2^RETIRE_W-1 to 0 with no flag.
- No stalls and no handshake: the writeback stage drives at most one write per cycle, and the block always accepts it.
- Latency: write at edge N is visible on ra/rt/ps after edge N (bypass disabled).

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Same-cycle forwarding. If wb.valid && wb.use_rw && wb.rw_addr == ra_addr, then ra = wb.data combinationally; likewise for rt.
  - If wb.valid && wb.write_ps, then ps output = wb.ps combinationally.
  - Stored state is identical to the non-bypass build.
- Undefined:
  - No forwarding paths; outputs reflect stored state only, as described in Behaviour.

Decomposition:
- Shared package nand_cpu_pkg, alongside the nand_cpu.svh macros:
  - REG_COUNT, REG_ADDR_W = $clog2(REG_COUNT), DATA_W.
  - typedef reg_addr_t (logic [REG_ADDR_W-1:0]).
  - typedef word_t (logic [DATA_W-1:0]).
- One natural sub-module, regfile_bank:
  - Contains the storage array, write decode and two read muxes.
  - The top level adds ps, retire_count and the optional bypass muxing.

Test Plan:
- Reset check: assert rst mid-run after writing r5=0x1234 -> ra(r5)=0x0000, ps=0 and retire_count=0 immediately, with no clock edge needed.
- Basic write/read: wb{valid=1,use_rw=1,rw_addr=3,data=0xBEEF} one cycle -> next cycle ra_addr=3 gives 0xBEEF; rt_addr=4 still gives 0x0000; retire_count=1.
- Gating: wb{valid=0,use_rw=1,write_ps=1,rw_addr=7,data=0xFFFF,ps=1} -> r7=0, ps=0, retire_count unchanged. Then valid=1, use_rw=0, write_ps=1, ps=1 -> ps=1, r7 still 0, retire_count +1.
- Same-address read during write: r2=0x0001, then write r2=0x00AA with ra_addr=rt_addr=2 in the same cycle.
  - Bypass disabled: ra=rt=0x0001 in the write cycle, 0x00AA after the edge.
  - REGFILE_BYPASS_EN defined: ra=rt=0x00AA within the write cycle.
- Counter wrap: 65536 consecutive valid writebacks from reset -> retire_count returns to 0x0000; one more gives 0x0001.
- All-register sweep: write r0..r15 = 0x1000+i, then read pairs (i, 15-i) -> ra=0x1000+i and rt=0x100F-i for every i.
